mem_bus_arbiter: RTL

Two-master arbiter and sequencer for the single memory-side line bus (bus 2). Two line-granular requesters, e.g. an instruction cache and a data cache, or a cache and a DMA engine, share one memory port. The arbiter grants masters round-robin and holds ownership for a whole line transaction, from command through all data beats to the memory response. It sits between the caches' bus-2 ports and the memory model, using unidirectional (non-tristate) signals.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the bus-2 memory arbiter:
// command codes, FSM states, beat count helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      C2_NOP        = 2'd0,
      C2_RESPONSE   = 2'd1,
      C2_READ_LINE  = 2'd2,
      C2_WRITE_LINE = 2'd3
   } c2_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WDATA,
      WAIT_RESP,
      RDATA
   } arb_state_t;

   function automatic int beats_of(
      input int line_bytes,
      input int data_w
   );
      return line_bytes * 8 / data_w;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick with its
// priority pointer; pointer moves on adv.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic       win
);

   logic ptr;

   // Lone requester wins; on a tie the pointer decides.
   always_comb begin
      win = req[1];
      if (req == 2'b11) win = ptr;
   end

   // Hand priority to the master that just lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= 1'b0;
      else if (adv) ptr <= ~win;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master line-bus arbiter/sequencer for bus 2.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 16,
   parameter int LINE_BYTES = 16,
   parameter int MAX_WAIT   = 255
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [1:0]        m0_cmd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_resp,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic [1:0]        m1_cmd,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_resp,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   localparam int BEATS = beats_of(LINE_BYTES, DATA_W);
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   arb_state_t        state;
   logic              owner;
   logic              is_wr;
   logic [CW-1:0]     cnt;
   logic [1:0]        gnt_q;
   logic [1:0]        req;
   logic              take;
   logic              win;
   logic [1:0]        sel_cmd;
   logic [ADDR_W-1:0] sel_addr;
   logic              in_wait;
   logic              fwd;
   logic              rd_ok;
   logic              tout;

   assign req = {m1_cmd != C2_NOP, m0_cmd != C2_NOP};
   assign take = (state == IDLE) && (req != 2'b00);
   assign sel_cmd = win ? m1_cmd : m0_cmd;
   assign sel_addr = win ? m1_addr : m0_addr;

   rr_arb2 u_rr (
      .clk   (CLK),
      .rst_n (RESET_N),
      .req   (req),
      .adv   (take),
      .win   (win)
   );

   // Line transaction sequencer with registered command side.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         owner    <= 1'b0;
         is_wr    <= 1'b0;
         cnt      <= '0;
         gnt_q    <= 2'b00;
         mem_cmd  <= C2_NOP;
         mem_addr <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  owner    <= win;
                  is_wr    <= (sel_cmd == C2_WRITE_LINE);
                  mem_cmd  <= sel_cmd;
                  mem_addr <= sel_addr;
                  gnt_q    <= win ? 2'b10 : 2'b01;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               mem_cmd  <= C2_NOP;
               mem_addr <= '0;
               gnt_q    <= 2'b00;
               if (is_wr) begin
                  cnt   <= CW'(1);
                  state <= (BEATS > 1) ? WDATA : WAIT_RESP;
               end else begin
                  cnt   <= '0;
                  state <= RDATA;
               end
            end
            WDATA: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (mem_resp || tout) state <= IDLE;
            end
            RDATA: begin
               if (mem_resp) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end else if (tout) begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_wait = (state == WAIT_RESP) || (state == RDATA);
   assign fwd     = in_wait && (mem_resp || tout);
   assign rd_ok   = (state == RDATA) && mem_resp;

   assign m0_gnt   = gnt_q[0];
   assign m1_gnt   = gnt_q[1];
   assign m0_resp  = fwd && !owner;
   assign m1_resp  = fwd && owner;
   assign m0_rdata = (rd_ok && !owner) ? mem_rdata : '0;
   assign m1_rdata = (rd_ok && owner) ? mem_rdata : '0;

   assign mem_wdata =
      (is_wr && (state == ISSUE || state == WDATA)) ?
      (owner ? m1_wdata : m0_wdata) : '0;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic [WW-1:0] wcnt;
   logic          err_q;

   // Idle-cycle watchdog while awaiting memory; err is sticky.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (!in_wait || mem_resp || tout) wcnt <= '0;
         else wcnt <= wcnt + 1'b1;
         if (tout) err_q <= 1'b1;
      end
   end

   assign tout = in_wait && !mem_resp &&
                 (wcnt == WW'(MAX_WAIT));
   assign err  = err_q;
`else
   // No watchdog in this build: never fires.
   assign tout = (MAX_WAIT < 0);
   assign err  = 1'b0;
`endif

endmodule
